// File: rtl/verifuck_pkg.sv
// Shared types and UART frame constants for the stdout UART sink.
package verifuck_pkg;

   // Transmitter state; every 2-bit encoding is a named state
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // 8N1 framing
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage

// File: rtl/stdout_uart_sink_if.sv
// Processor output port: byte, valid level and the enable that stalls the processor.
interface stdout_uart_sink_if import verifuck_pkg::*;;

   logic [DATA_BITS-1:0] stdout;
   logic                 stdout_en;
   logic                 proc_en;

   // The processor drives the byte and its valid level and is stalled by proc_en
   modport master (output stdout, output stdout_en, input proc_en);
   // The sink consumes the byte and owns the back-pressure enable
   modport slave  (input stdout, input stdout_en, output proc_en);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is readable
// combinationally and is consumed by pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO or a pop from an empty one is ignored
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem[rd_ptr_q];

   // Pointers wrap naturally at DEPTH; count tracks push/pop, unchanged when both happen
   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage write
   // NOTE: the array has no reset; stale contents are unreachable once the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/stdout_uart_sink.sv
// Buffers processor output bytes in a FIFO and sends them as 8N1 UART
// frames, LSB first. The processor is stalled through proc_en while the
// FIFO is full, so no byte is dropped.
module stdout_uart_sink import verifuck_pkg::*; #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 16,
   parameter int FIFO_AW      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   stdout_uart_sink_if.slave    bus,
   input  logic                 run,
   output logic                 txd,
   output logic                 tx_busy,
   output logic [FIFO_AW:0]     fifo_count
);

   localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 push;
   logic                 pop;

   tx_state_e            state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 txd_q, txd_d;
   logic                 bit_done;
   logic                 stop_done;

   // Back-pressure: the count is registered, so space freed by a pop shows up a cycle later
   assign bus.proc_en = run & ~fifo_full;
   assign push        = bus.stdout_en & bus.proc_en;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.stdout),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bit_done  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign stop_done = (baud_q == BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1));

   assign txd     = txd_q;
   assign tx_busy = (state_q != IDLE);

   // Transmitter registers; txd is registered so the line never glitches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   // Next-state, line level and FIFO pop for the 8N1 frame sequencer
   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = 1'b1;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_head;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            txd_d = 1'b0;
            if (bit_done) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            txd_d = shift_q[0];
            if (bit_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (stop_done) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stdout_uart_sink.sv
// Bench for stdout_uart_sink: a processor-like driver pushes expected
// bytes into a scoreboard queue at capture time, and a UART receiver
// decodes txd and compares each frame against the queue head.
module tb_stdout_uart_sink;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          run   = 1'b1;
   logic          txd;
   logic          tx_busy;
   logic [AW:0]   fifo_count;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [7:0]    exp_q[$];
   bit            rx_abort = 1'b0;

   stdout_uart_sink_if bus_if ();

   stdout_uart_sink #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .FIFO_AW      (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus_if),
      .run        (run),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   // Processor model: hold the byte until an enabled edge, then drop valid
   task automatic put_byte(input logic [7:0] b, output int waited);
      waited = 0;
      bus_if.stdout    = b;
      bus_if.stdout_en = 1'b1;
      #1;
      while (!bus_if.proc_en && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (!bus_if.proc_en) check("put_timeout", waited, 0);
      else exp_q.push_back(b);
      @(negedge clk);
      bus_if.stdout_en = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || tx_busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // UART receiver: sample mid-bit and score each completed frame
   initial begin : uart_rx
      logic [7:0] rx;
      logic       start_ok;
      logic       stop_ok;
      forever begin
         @(negedge txd);
         rx_abort = 1'b0;
         repeat (2) @(negedge clk);
         start_ok = (txd == 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rx[i] = txd;
         end
         repeat (CPB) @(negedge clk);
         stop_ok = txd;
         if (!rx_abort) begin
            check("rx_start_bit", start_ok, 1);
            check("rx_stop_bit", stop_ok, 1);
            if (exp_q.size() == 0) check("rx_extra_frame", exp_q.size(), 1);
            else check("rx_byte", rx, exp_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w;
      int busy;
      int bad;

      bus_if.stdout    = '0;
      bus_if.stdout_en = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_txd", txd, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_proc_en_run1", bus_if.proc_en, 1);
      run = 1'b0;
      #1 check("rst_proc_en_run0", bus_if.proc_en, 0);
      run = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single byte 0x48: latency, frame length, count return
      put_byte(8'h48, w);
      check("t1_count_after_push", fifo_count, 1);
      check("t1_txd_idle", txd, 1);
      check("t1_busy_before_pop", tx_busy, 0);
      @(negedge clk);
      check("t1_busy_after_pop", tx_busy, 1);
      check("t1_txd_still_high", txd, 1);
      check("t1_count_after_pop", fifo_count, 0);
      @(negedge clk);
      check("t1_txd_start", txd, 0);
      busy = 2;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!tx_busy) break;
         busy++;
      end
      check("t1_busy_cycles", busy, 40);
      wait_drain();

      // Six back-to-back bytes: fill the FIFO, stall, resume after the next pop
      for (int i = 1; i <= 5; i++) begin
         put_byte(i[7:0], w);
         check("t2_no_stall", w, 0);
      end
      check("t2_count_full", fifo_count, DEPTH);
      check("t2_proc_en_full", bus_if.proc_en, 0);
      put_byte(8'h06, w);
      check("t2_stall_cycles", w, 38);
      wait_drain();

      // run low: valid held for 20 cycles must not push
      run = 1'b0;
      bus_if.stdout    = 8'h5A;
      bus_if.stdout_en = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_count != 0 || bus_if.proc_en) bad++;
      end
      check("t3_no_push_run0", bad, 0);
      run = 1'b1;
      put_byte(8'h5A, w);
      check("t3_no_stall", w, 0);
      check("t3_push_count", fifo_count, 1);
      @(negedge clk);
      check("t3_single_push", fifo_count, 0);
      wait_drain();

      // Reset during data bit 3 of 0x55 with two bytes still queued
      put_byte(8'h55, w);
      put_byte(8'h66, w);
      put_byte(8'h77, w);
      repeat (17) @(negedge clk);
      check("t4_bit3_level", txd, 0);
      reset    = 1'b0;
      rx_abort = 1'b1;
      #1;
      check("t4_txd_async", txd, 1);
      check("t4_count_async", fifo_count, 0);
      check("t4_busy_async", tx_busy, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (txd !== 1'b1 || fifo_count != 0 || tx_busy) bad++;
      end
      check("t4_quiet_after_reset", bad, 0);

      // Push and pop on the same edge with two entries queued
      put_byte(8'hA0, w);
      put_byte(8'hA1, w);
      put_byte(8'hA2, w);
      for (int i = 0; i < 200; i++) begin
         if (!tx_busy) break;
         @(negedge clk);
      end
      check("t5_idle_reached", tx_busy, 0);
      check("t5_count_before", fifo_count, 2);
      put_byte(8'hA3, w);
      check("t5_count_after", fifo_count, 2);
      check("t5_popped", tx_busy, 1);
      wait_drain();

      // All-zero and all-one data fields
      put_byte(8'h00, w);
      put_byte(8'hFF, w);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
